// File: rtl/railway_pkg.sv
// Shared types and constants for the mouse click tracker: screen size defaults,
// FSM encoding, the point record and the box-hit helper used by the pixel flags.
package railway_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_SET = 2'd1,
    BOTH_SET  = 2'd2,
    WAIT_CLR  = 2'd3
  } sel_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } point_t;

  // |a - c| <= r, evaluated in 11-bit signed so coordinates near 0 or the far edge never wrap.
  function automatic logic in_box(input logic [9:0] a, input logic [9:0] c, input int unsigned r);
    logic signed [10:0] d;
    logic signed [10:0] rs;
    d  = $signed({1'b0, a}) - $signed({1'b0, c});
    rs = $signed(11'(r));
    return (d <= rs) && (d >= -rs);
  endfunction

endpackage

// File: rtl/mouse_click_tracker_if.sv
// Bundle of mouse inputs, pixel coordinates, path-engine handshake and marker outputs.
interface mouse_click_tracker_if;

  logic       frame_clk;
  logic       LEFT;
  logic       RIGHT;
  logic       key1;
  logic [9:0] XMOV_MOUSE;
  logic [9:0] YMOV_MOUSE;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       path_ack;
  logic       is_mouse;
  logic       is_start_mark;
  logic       is_end_mark;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic [9:0] end_x;
  logic [9:0] end_y;
  logic       path_req;
  logic [1:0] sel_state;

  modport master (
    output frame_clk, LEFT, RIGHT, key1, XMOV_MOUSE, YMOV_MOUSE, DrawX, DrawY, path_ack,
    input  is_mouse, is_start_mark, is_end_mark, start_x, start_y, end_x, end_y, path_req,
           sel_state
  );

  modport slave (
    input  frame_clk, LEFT, RIGHT, key1, XMOV_MOUSE, YMOV_MOUSE, DrawX, DrawY, path_ack,
    output is_mouse, is_start_mark, is_end_mark, start_x, start_y, end_x, end_y, path_req,
           sel_state
  );

endinterface

// File: rtl/mouse_click_tracker_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/mouse_click_tracker.sv
// Turns synchronised mouse clicks into a start/end point pair with a req/ack handshake
// to the path engine, and flags cursor and marker pixels for the colour mapper.
module mouse_click_tracker
  import railway_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned CUR_R    = 1,
  parameter int unsigned MARK_R   = 2
) (
  input logic                  Clk,
  input logic                  Reset,
  mouse_click_tracker_if.slave bus_io
);

  localparam logic [9:0] XMax = 10'(H_ACTIVE - 1);
  localparam logic [9:0] YMax = 10'(V_ACTIVE - 1);

  logic l_rise, r_rise, frame_rise, key1_s;
  logic unused_l_level, unused_r_level, unused_frame_level, unused_key1_rise;

  sync_edge u_sync_left (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .d_i     (bus_io.LEFT),
    .level_o (unused_l_level),
    .rise_o  (l_rise)
  );

  sync_edge u_sync_right (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .d_i     (bus_io.RIGHT),
    .level_o (unused_r_level),
    .rise_o  (r_rise)
  );

  sync_edge u_sync_frame (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .d_i     (bus_io.frame_clk),
    .level_o (unused_frame_level),
    .rise_o  (frame_rise)
  );

  sync_edge u_sync_key1 (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .d_i     (bus_io.key1),
    .level_o (key1_s),
    .rise_o  (unused_key1_rise)
  );

  sel_state_t state_q, state_d;
  point_t     cur_q, cur_d;
  point_t     start_q, start_d;
  point_t     end_q, end_d;
  logic       req_q, req_d;

  logic       click_l, click_r;
  logic [9:0] x_clamp, y_clamp;

  assign click_l = l_rise & key1_s;
  assign click_r = r_rise & key1_s;
  assign x_clamp = (bus_io.XMOV_MOUSE > XMax) ? XMax : bus_io.XMOV_MOUSE;
  assign y_clamp = (bus_io.YMOV_MOUSE > YMax) ? YMax : bus_io.YMOV_MOUSE;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    end_d   = end_q;
    req_d   = req_q;

    // Cursor only moves once per frame so it never tears mid-scan.
    if (frame_rise) begin
      cur_d.x = x_clamp;
      cur_d.y = YMax - y_clamp;
    end

    unique case (state_q)
      IDLE: begin
        if (click_l && !click_r) begin
          start_d = cur_q;
          state_d = START_SET;
        end
      end
      START_SET: begin
        if (click_r) begin
          state_d = IDLE;
        end else if (click_l) begin
          end_d   = cur_q;
          req_d   = 1'b1;
          state_d = BOTH_SET;
        end
      end
      BOTH_SET: begin
        if (click_r) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (bus_io.path_ack) begin
          req_d   = 1'b0;
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (click_r) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      end_q   <= end_d;
      req_q   <= req_d;
    end
  end

  assign bus_io.is_mouse = in_box(bus_io.DrawX, cur_q.x, CUR_R) &
                           in_box(bus_io.DrawY, cur_q.y, CUR_R);
  assign bus_io.is_start_mark = (state_q != IDLE) &
                                in_box(bus_io.DrawX, start_q.x, MARK_R) &
                                in_box(bus_io.DrawY, start_q.y, MARK_R);
  assign bus_io.is_end_mark = ((state_q == BOTH_SET) || (state_q == WAIT_CLR)) &
                              in_box(bus_io.DrawX, end_q.x, MARK_R) &
                              in_box(bus_io.DrawY, end_q.y, MARK_R);

  assign bus_io.start_x   = start_q.x;
  assign bus_io.start_y   = start_q.y;
  assign bus_io.end_x     = end_q.x;
  assign bus_io.end_y     = end_q.y;
  assign bus_io.path_req  = req_q;
  assign bus_io.sel_state = state_q;

endmodule

// File: tb/tb_mouse_click_tracker.sv
// Directed bench for mouse_click_tracker: expectations are queued as stimulus is driven
// and popped against DUT outputs.
module tb_mouse_click_tracker;

  logic Clk;
  logic Reset;

  mouse_click_tracker_if bus ();

  mouse_click_tracker #(
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .CUR_R    (1),
    .MARK_R   (2)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed=%0d required=<queued expectation>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
  endtask

  task automatic frame();
    bus.frame_clk = 1'b1;
    tick(3);
    bus.frame_clk = 1'b0;
    tick(3);
  endtask

  task automatic press_left();
    bus.LEFT = 1'b1;
    tick(3);
    bus.LEFT = 1'b0;
    tick(3);
  endtask

  task automatic press_right();
    bus.RIGHT = 1'b1;
    tick(3);
    bus.RIGHT = 1'b0;
    tick(3);
  endtask

  initial begin
    Reset          = 1'b1;
    bus.frame_clk  = 1'b0;
    bus.LEFT       = 1'b0;
    bus.RIGHT      = 1'b0;
    bus.key1       = 1'b0;
    bus.XMOV_MOUSE = '0;
    bus.YMOV_MOUSE = '0;
    bus.DrawX      = 10'd5;
    bus.DrawY      = 10'd5;
    bus.path_ack   = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(1);

    // Reset state
    push("rst_state", 0); push("rst_req", 0); push("rst_start_x", 0); push("rst_end_y", 0);
    push("rst_mouse", 0); push("rst_smark", 0); push("rst_emark", 0);
    check(bus.sel_state); check(bus.path_req); check(bus.start_x); check(bus.end_y);
    check(bus.is_mouse); check(bus.is_start_mark); check(bus.is_end_mark);

    // Cursor latch and flip: (100,380) -> (100,99)
    bus.XMOV_MOUSE = 10'd100;
    bus.YMOV_MOUSE = 10'd380;
    frame();
    push("cur_in_101_100", 1);  pix(101, 100); check(bus.is_mouse);
    push("cur_out_102_99", 0);  pix(102, 99);  check(bus.is_mouse);
    push("cur_in_99_98", 1);    pix(99, 98);   check(bus.is_mouse);
    push("cur_out_100_101", 0); pix(100, 101); check(bus.is_mouse);

    // First point
    bus.key1 = 1'b1;
    tick(3);
    press_left();
    push("start_state", 1); push("start_x", 100); push("start_y", 99);
    check(bus.sel_state); check(bus.start_x); check(bus.start_y);
    push("smark_in", 1);  pix(102, 101); check(bus.is_start_mark);
    push("smark_out", 0); pix(103, 99);  check(bus.is_start_mark);

    // Second point: req rises exactly 3 cycles after the press
    bus.XMOV_MOUSE = 10'd300;
    bus.YMOV_MOUSE = 10'd279;
    frame();
    bus.LEFT = 1'b1;
    tick(2);
    push("req_early", 0); check(bus.path_req);
    tick(1);
    push("req_rise", 1); push("end_x", 300); push("end_y", 200); push("both_state", 2);
    check(bus.path_req); check(bus.end_x); check(bus.end_y); check(bus.sel_state);
    bus.LEFT = 1'b0;
    tick(3);

    // Handshake held without ack
    tick(50);
    push("req_hold", 1); push("end_x_hold", 300); push("end_y_hold", 200);
    check(bus.path_req); check(bus.end_x); check(bus.end_y);
    bus.path_ack = 1'b1;
    tick(1);
    bus.path_ack = 1'b0;
    push("req_drop", 0); push("wait_state", 3);
    check(bus.path_req); check(bus.sel_state);
    push("emark_wait", 1); pix(300, 200); check(bus.is_end_mark);
    push("smark_wait", 1); pix(100, 99);  check(bus.is_start_mark);

    // click_l ignored in WAIT_CLR
    press_left();
    push("wait_ignore_l", 3); push("wait_start_kept", 100);
    check(bus.sel_state); check(bus.start_x);

    // Right click clears state but keeps points
    press_right();
    push("rclick_idle", 0); push("points_kept", 100);
    check(bus.sel_state); check(bus.start_x);
    push("smark_idle", 0); pix(100, 99); check(bus.is_start_mark);

    // Simultaneous L+R in START_SET: right wins
    press_left();
    push("restart", 1); push("restart_x", 300);
    check(bus.sel_state); check(bus.start_x);
    bus.LEFT  = 1'b1;
    bus.RIGHT = 1'b1;
    tick(3);
    push("lr_idle", 0); push("lr_req", 0);
    check(bus.sel_state); check(bus.path_req);
    push("lr_smark", 0); pix(300, 200); check(bus.is_start_mark);
    bus.LEFT  = 1'b0;
    bus.RIGHT = 1'b0;
    tick(3);

    // key1 low blocks clicks
    bus.key1 = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) press_left();
    push("key1_low_state", 0); push("key1_low_req", 0);
    check(bus.sel_state); check(bus.path_req);

    // Held button gives one click
    bus.key1 = 1'b1;
    tick(3);
    bus.LEFT = 1'b1;
    tick(1000);
    push("hold_one", 1); check(bus.sel_state);
    bus.LEFT = 1'b0;
    tick(3);
    push("hold_release", 1); check(bus.sel_state);

    // path_ack ignored while req low
    bus.path_ack = 1'b1;
    tick(2);
    bus.path_ack = 1'b0;
    push("ack_ignored", 1); push("ack_ignored_req", 0);
    check(bus.sel_state); check(bus.path_req);

    // Clamp at screen corner; cursor update latency 3 cycles
    bus.XMOV_MOUSE = 10'd1023;
    bus.YMOV_MOUSE = 10'd0;
    bus.DrawX      = 10'd638;
    bus.DrawY      = 10'd478;
    bus.frame_clk  = 1'b1;
    tick(2);
    push("cur_lat_old", 0); check(bus.is_mouse);
    tick(1);
    push("cur_lat_new", 1); check(bus.is_mouse);
    bus.frame_clk = 1'b0;
    tick(3);
    push("edge_639_479", 1); pix(639, 479); check(bus.is_mouse);
    push("no_wrap_0_479", 0); pix(0, 479); check(bus.is_mouse);
    push("no_wrap_639_0", 0); pix(639, 0); check(bus.is_mouse);

    // End point at corner, then async reset mid-handshake
    press_left();
    push("corner_both", 2); push("corner_end_x", 639); push("corner_end_y", 479);
    push("corner_req", 1);
    check(bus.sel_state); check(bus.end_x); check(bus.end_y); check(bus.path_req);
    push("corner_emark", 1); pix(637, 477); check(bus.is_end_mark);
    #3;
    Reset = 1'b1;
    #1;
    push("async_req", 0); push("async_state", 0);
    check(bus.path_req); check(bus.sel_state);
    tick(1);
    Reset = 1'b0;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
